// File: rtl/dmem_unit_pkg.sv
// Shared types and constants for the data-memory stage: store encodings,
// MMIO register map, status bit positions and the MMIO request bundle.
package dmem_unit_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } memwrite_t;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int VEC_W     = NUM_LANES * LANE_W;

  localparam logic [15:0] OFF_CYCLE   = 16'h0000;
  localparam logic [15:0] OFF_COMPARE = 16'h0004;
  localparam logic [15:0] OFF_STATUS  = 16'h0008;
  localparam logic [15:0] OFF_BADADDR = 16'h000C;

  localparam int ST_TIMER    = 0;
  localparam int ST_MISALIGN = 1;

  typedef struct packed {
    logic             we;     // aligned word store into the MMIO window
    logic [15:0]      off;    // word-granular offset, low two bits zero
    logic [VEC_W-1:0] wdata;
  } mmio_req_t;

  function automatic logic st_aligned(memwrite_t mw, logic [1:0] lo);
    case (mw)
      MW_WORD: return lo == 2'b00;
      MW_HALF: return !lo[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_unit_if.sv
// M-stage memory bus between the core (master) and the data-memory stage (slave).
interface dmem_unit_if;
  import dmem_unit_pkg::*;

  logic [1:0]       memwrite;
  logic [31:0]      addr;
  logic [VEC_W-1:0] writedata;
  logic [VEC_W-1:0] readdata;

  modport master (output memwrite, output addr, output writedata, input readdata);
  modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/dmem_unit_mmio_regs.sv
// MMIO register block: free-running cycle counter, timer compare, sticky
// W1C status, misaligned-store address capture and the MMIO read mux.
module dmem_mmio_regs
  import dmem_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  mmio_req_t        req,
  input  logic             misalign_evt,
  input  logic [31:0]      evt_addr,
  output logic [VEC_W-1:0] rdata,
  output logic             irq,
  output logic             misalign
);

  logic [31:0] cycle, compare, badaddr;
  logic [1:0]  status, status_nxt;
  logic        wr_compare, wr_status, match;

  assign wr_compare = req.we && (req.off == OFF_COMPARE);
  assign wr_status  = req.we && (req.off == OFF_STATUS);
  // Match uses the counter and compare value as they stand before this edge.
  assign match      = (cycle == compare);

  // Clear first, then apply sets so a same-cycle set beats the W1C.
  always_comb begin
    status_nxt = status & ~(wr_status ? req.wdata[1:0] : 2'b00);
    if (match)        status_nxt[ST_TIMER]    = 1'b1;
    if (misalign_evt) status_nxt[ST_MISALIGN] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle   <= '0;
      compare <= 32'hFFFF_FFFF;
      status  <= '0;
      badaddr <= '0;
    end else begin
      cycle  <= cycle + 32'd1;
      status <= status_nxt;
      if (wr_compare)   compare <= req.wdata;
      if (misalign_evt) badaddr <= evt_addr;
    end
  end

  always_comb begin
    rdata = '0;
    case (req.off)
      OFF_CYCLE:   rdata = cycle;
      OFF_COMPARE: rdata = compare;
      OFF_STATUS:  rdata = {30'd0, status};
      OFF_BADADDR: rdata = badaddr;
      default:     rdata = '0;
    endcase
  end

  assign irq      = status[ST_TIMER];
  assign misalign = status[ST_MISALIGN];

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: byte-lane word RAM with zero-latency read, store lane
// merging, misaligned-store suppression, and a small MMIO register window.
module dmem_unit
  import dmem_unit_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic      clk,
  input  logic      reset,
  dmem_unit_if.slave bus,
  output logic      irq,
  output logic      misalign
);

  localparam int AW = $clog2(DEPTH);

  memwrite_t                          mw;
  logic                               is_mmio, aligned, st_vld, st_bad, ram_wr;
  logic [AW-1:0]                      widx;
  logic [NUM_LANES-1:0]               lane_en;
  logic [NUM_LANES-1:0][LANE_W-1:0]   lane_wdata, ram_rd;
  logic [VEC_W-1:0]                   mmio_rdata;
  mmio_req_t                          mreq;

  assign mw      = memwrite_t'(bus.memwrite);
  assign is_mmio = (bus.addr[31:16] == MMIO_BASE[31:16]);
  assign aligned = st_aligned(mw, bus.addr[1:0]);
  assign st_vld  = (mw != MW_NONE);
  assign st_bad  = st_vld && !aligned;
  assign widx    = bus.addr[AW+1:2];
  // Stores are dropped while reset is held; RAM contents survive reset.
  assign ram_wr  = reset && st_vld && aligned && !is_mmio;

  // Replicating the right-aligned data lets each lane pick its own slice.
  always_comb begin
    lane_en    = '0;
    lane_wdata = bus.writedata;
    case (mw)
      MW_WORD: begin
        lane_en    = '1;
        lane_wdata = bus.writedata;
      end
      MW_HALF: begin
        lane_en    = bus.addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{bus.writedata[15:0]}};
      end
      MW_BYTE: begin
        lane_en    = 4'b0001 << bus.addr[1:0];
        lane_wdata = {4{bus.writedata[7:0]}};
      end
      default: begin
        lane_en    = '0;
        lane_wdata = bus.writedata;
      end
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (ram_wr && lane_en[l]) mem[widx] <= lane_wdata[l];
    end

    assign ram_rd[l] = mem[widx];
  end

  assign mreq.we    = is_mmio && (mw == MW_WORD) && aligned;
  assign mreq.off   = {bus.addr[15:2], 2'b00};
  assign mreq.wdata = bus.writedata;

  dmem_mmio_regs u_regs (
    .clk          (clk),
    .reset        (reset),
    .req          (mreq),
    .misalign_evt (st_bad),
    .evt_addr     (bus.addr),
    .rdata        (mmio_rdata),
    .irq          (irq),
    .misalign     (misalign)
  );

  assign bus.readdata = is_mmio ? mmio_rdata : ram_rd;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: behavioural model plus directed and random traffic.
module tb_dmem_unit;
  import dmem_unit_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq, misalign;
  always #5 clk = ~clk;

  dmem_unit_if bus ();

  dmem_unit #(.DEPTH(DEPTH), .INIT_FILE(""), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .irq      (irq),
    .misalign (misalign)
  );

  // behavioural model state
  logic [31:0] m_ram [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_cycle, m_compare, m_badaddr;
  logic [1:0]  m_status;
  logic [31:0] fillv [DEPTH];
  bit          chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int st_size(input logic [1:0] mw);
    case (mw)
      2'b01: return 4;
      2'b10: return 2;
      2'b11: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (in_mmio(a)) begin
      case (a[15:0] & 16'hFFFC)
        16'h0000: return m_cycle;
        16'h0004: return m_compare;
        16'h0008: return {30'd0, m_status};
        16'h000C: return m_badaddr;
        default:  return 32'd0;
      endcase
    end
    return m_ram[word_idx(a)];
  endfunction

  always @(posedge clk) begin : p_model
    logic [31:0] a, d;
    int sz, base, idx;
    bit match;
    a  = bus.addr;
    d  = bus.writedata;
    sz = st_size(bus.memwrite);
    if (!reset) begin
      m_cycle   = 32'd0;
      m_compare = 32'hFFFF_FFFF;
      m_status  = 2'b00;
      m_badaddr = 32'd0;
    end else begin
      match = (m_cycle == m_compare);
      if (sz != 0 && (a % sz) != 0) begin
        m_status[1] = 1'b1;
        m_badaddr   = a;
      end else if (sz != 0 && !in_mmio(a)) begin
        idx  = word_idx(a);
        base = int'(a % 4);
        for (int k = 0; k < sz; k++) m_ram[idx][8*(base+k) +: 8] = d[8*k +: 8];
        if (sz == 4) m_known[idx] = 1'b1;
      end else if (sz == 4) begin
        if (a[15:0] == 16'h0004)      m_compare = d;
        else if (a[15:0] == 16'h0008) m_status  = m_status & ~d[1:0];
      end
      if (match) m_status[0] = 1'b1;
      m_cycle = m_cycle + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("irq", {31'd0, irq}, {31'd0, m_status[0]});
      chk("misalign", {31'd0, misalign}, {31'd0, m_status[1]});
      if (in_mmio(bus.addr) || m_known[word_idx(bus.addr)])
        chk("readdata", bus.readdata, m_read(bus.addr));
    end
  end

  task automatic drive(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.memwrite  = mw;
    bus.addr      = a;
    bus.writedata = d;
  endtask

  initial begin
    logic [31:0] a, d, v;
    logic [1:0]  mw;
    int r;
    bus.memwrite = 2'b00;
    bus.addr = 32'd0;
    bus.writedata = 32'd0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    // reset state
    drive(0, 32'hFFFF_0004, 0);
    drive(0, 32'hFFFF_0004, 0);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_compare", bus.readdata, 32'hFFFF_FFFF);
    drive(0, 32'hFFFF_0000, 0);
    @(negedge clk);
    chk("rst_cycle", bus.readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // release and preload every RAM word
    drive(0, 32'd0, 0);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      fillv[i] = v;
      drive(1, i * 4, v);
    end

    // lane merging
    drive(1, 32'h10, 32'h1122_3344);
    drive(3, 32'h12, 32'h0000_00AA);
    drive(2, 32'h10, 32'h0000_BEEF);
    drive(0, 32'h10, 0);
    @(negedge clk);
    chk("lanes", bus.readdata, 32'h11AA_BEEF);
    drive(1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rdw_old", bus.readdata, 32'h11AA_BEEF);
    drive(0, 32'h10, 0);
    @(negedge clk);
    chk("rdw_new", bus.readdata, 32'hDEAD_BEEF);

    // misaligned word store
    drive(1, 32'h21, 32'h1234_5678);
    drive(0, 32'hFFFF_000C, 0);
    @(negedge clk);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_badaddr", bus.readdata, 32'h21);
    drive(0, 32'h20, 0);
    @(negedge clk);
    chk("mis_ram", bus.readdata, fillv[8]);
    drive(1, 32'hFFFF_0008, 32'h2);
    drive(0, 32'hFFFF_0008, 0);
    @(negedge clk);
    chk("w1c_status", bus.readdata, 32'd0);
    chk("w1c_misalign", {31'd0, misalign}, 32'd0);

    // MMIO odds and ends
    drive(3, 32'hFFFF_0004, 32'h12);
    drive(0, 32'hFFFF_0004, 0);
    @(negedge clk);
    chk("byte_compare", bus.readdata, 32'hFFFF_FFFF);
    chk("byte_noflag", {31'd0, misalign}, 32'd0);
    drive(0, 32'hFFFF_0010, 0);
    @(negedge clk);
    chk("off10", bus.readdata, 32'd0);
    drive(1, 32'hFFFF_0000, 32'd0);
    drive(0, 32'hFFFF_0000, 0);

    // reset with a store pending
    drive(1, 32'h40, 32'hCAFE_F00D);
    reset = 1'b0;
    drive(0, 32'hFFFF_0000, 0);
    @(negedge clk);
    chk("rmid_cycle", bus.readdata, 32'd0);
    chk("rmid_irq", {31'd0, irq}, 32'd0);
    drive(0, 32'hFFFF_0004, 0);
    @(negedge clk);
    chk("rmid_compare", bus.readdata, 32'hFFFF_FFFF);
    drive(0, 32'h40, 0);
    @(negedge clk);
    chk("rmid_ram", bus.readdata, fillv[16]);

    // timer: COMPARE=5 on the first edge out of reset
    drive(1, 32'hFFFF_0004, 32'd5);
    reset = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      drive(0, 32'hFFFF_0000, 0);
      @(negedge clk);
      chk("tmr_cycle", bus.readdata, j);
      chk("tmr_irq", {31'd0, irq}, (j >= 6) ? 32'd1 : 32'd0);
    end
    drive(1, 32'hFFFF_0004, 32'd12);
    drive(1, 32'hFFFF_0008, 32'd1);
    drive(0, 32'hFFFF_0008, 0);
    @(negedge clk);
    chk("tmr_clr", {31'd0, irq}, 32'd0);
    drive(1, 32'hFFFF_0008, 32'd1);
    @(negedge clk);
    chk("tmr_pre", {31'd0, irq}, 32'd0);
    drive(0, 32'hFFFF_0008, 0);
    @(negedge clk);
    chk("tmr_setwins", {31'd0, irq}, 32'd1);

    // counter wrap with COMPARE=0
    drive(1, 32'hFFFF_0004, 32'd0);
    drive(1, 32'hFFFF_0008, 32'd1);
    drive(0, 32'hFFFF_0008, 0);
    @(negedge clk);
    chk("wrap_clr", {31'd0, irq}, 32'd0);
    force dut.u_regs.cycle = 32'hFFFF_FFFE;
    m_cycle = 32'hFFFF_FFFE;
    #1;
    release dut.u_regs.cycle;
    drive(0, 32'hFFFF_0000, 0);
    @(negedge clk);
    chk("wrap_max", bus.readdata, 32'hFFFF_FFFF);
    drive(0, 32'hFFFF_0000, 0);
    @(negedge clk);
    chk("wrap_zero", bus.readdata, 32'd0);
    chk("wrap_noirq", {31'd0, irq}, 32'd0);
    drive(0, 32'hFFFF_0000, 0);
    @(negedge clk);
    chk("wrap_irq", {31'd0, irq}, 32'd1);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      mw = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      d  = $urandom;
      if (r < 6) begin
        a = $urandom;
        if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          if (mw == 2'b01)      a[1:0] = 2'b00;
          else if (mw == 2'b10) a[0]   = 1'b0;
        end
      end else begin
        a = 32'hFFFF_0000 | ($urandom_range(0, 5) * 4);
        if (r == 9) a[1:0] = 2'($urandom_range(0, 3));
        if (a[15:0] == 16'h0004 && $urandom_range(0, 1) == 1) d = m_cycle + $urandom_range(1, 6);
        if (a[15:0] == 16'h0008) d = {30'd0, 2'($urandom_range(0, 3))};
      end
      drive(mw, a, d);
      reset = ($urandom_range(0, 99) != 0);
    end
    drive(0, 32'd0, 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
